uart_bus_responder: RTL and testbench

//  Device-side model of the UART bus strobed by the CPU RAM1/UART controller (wrn/rdn, data_ready/tbre/tsre).

---
 rtl/uart_bus_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_responder
// Description : Device-side stand-in for the external UART chip on the CPU
//               RAM1/UART bus. Bytes written on the wrn rising edge are
//               serialised 8N1 on txd_o; bytes received on rxd_i are held in
//               a receive buffer and offered on the shared data bus while
//               rdn is low.
// Ports       : CLK, RST          - clock, synchronous active-high reset
//               wrn_i, data_i     - write strobe (active low) and write data
//               rdn_i             - read strobe (active low)
//               data_o, data_oe_o - receive buffer and bus drive enable
//               data_ready_o      - unread byte available
//               tbre_o, tsre_o    - holding register / shift register empty
//               overrun_o         - sticky receive overrun
//               txd_o, rxd_i      - serial transmit / receive lines
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_responder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wrn_i,
    input  logic       rdn_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe_o,
    output logic       data_ready_o,
    output logic       tbre_o,
    output logic       tsre_o,
    output logic       overrun_o,
    output logic       txd_o,
    input  logic       rxd_i
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_HALF = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Bus strobes: one register stage, edge = previous low, current high
    // ------------------------------------------------------------------
    logic r_wrn_cur, r_wrn_prev, r_rdn_cur, r_rdn_prev, r_data_oe;
    logic w_wr_edge, w_rd_edge;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wrn_cur  <= 1'b1;
            r_wrn_prev <= 1'b1;
            r_rdn_cur  <= 1'b1;
            r_rdn_prev <= 1'b1;
            r_data_oe  <= 1'b0;
        end else begin
            r_wrn_cur  <= wrn_i;
            r_wrn_prev <= r_wrn_cur;
            r_rdn_cur  <= rdn_i;
            r_rdn_prev <= r_rdn_cur;
            r_data_oe  <= ~rdn_i;
        end
    end

    assign w_wr_edge = ~r_wrn_prev & r_wrn_cur;
    assign w_rd_edge = ~r_rdn_prev & r_rdn_cur;

    // ------------------------------------------------------------------
    // Transmit: holding register, shifter and framing FSM
    // ------------------------------------------------------------------
    state_t                r_tx_state;
    logic [c_BAUD_W-1:0]   r_tx_baud;
    logic [2:0]            r_tx_bit;
    logic [7:0]            r_thr;
    logic [7:0]            r_tx_shift;
    logic                  r_tbre, r_tsre, r_txd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state <= ST_IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= 3'd0;
            r_thr      <= 8'h00;
            r_tx_shift <= 8'h00;
            r_tbre     <= 1'b1;
            r_tsre     <= 1'b1;
            r_txd      <= 1'b1;
        end else begin
            // A write is accepted only while the holding register is empty;
            // the reload paths below all require it full, so they never collide.
            if (w_wr_edge && r_tbre) begin
                r_thr  <= data_i;
                r_tbre <= 1'b0;
            end

            r_tx_baud <= r_tx_baud + 1'b1;
            case (r_tx_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (!r_tbre) begin
                        r_tx_shift <= r_thr;
                        r_tbre     <= 1'b1;
                        r_tsre     <= 1'b0;
                        r_txd      <= 1'b0;
                        r_tx_baud  <= '0;
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_tx_baud == c_BAUD_LAST) begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_baud  <= '0;
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_tx_baud == c_BAUD_LAST) begin
                        r_tx_baud <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_bit   <= 3'd0;
                            r_tx_state <= ST_STOP;
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_tx_baud == c_BAUD_LAST) begin
                        r_tx_baud <= '0;
                        r_tx_bit  <= 3'd0;
                        if (!r_tbre) begin
                            // Next byte already waiting: start its frame with no idle gap
                            r_tx_shift <= r_thr;
                            r_tbre     <= 1'b1;
                            r_txd      <= 1'b0;
                            r_tx_state <= ST_START;
                        end else begin
                            r_tsre     <= 1'b1;
                            r_tx_state <= ST_IDLE;
                        end
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive: synchroniser, mid-bit sampling FSM, buffer and flags
    // ------------------------------------------------------------------
    state_t                r_rx_state;
    logic [c_BAUD_W-1:0]   r_rx_baud;
    logic [2:0]            r_rx_bit;
    logic [7:0]            r_rx_shift;
    logic [7:0]            r_rbr;
    logic                  r_rx_s1, r_rx_s2, r_rx_prev;
    logic                  r_data_ready, r_overrun;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_state   <= ST_IDLE;
            r_rx_baud    <= '0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_rbr        <= 8'h00;
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_s1   <= rxd_i;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;

            if (w_rd_edge) begin
                r_data_ready <= 1'b0;
                r_overrun    <= 1'b0;
            end

            r_rx_baud <= r_rx_baud + 1'b1;
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_baud  <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Half-bit re-check rejects glitches; passing aligns sampling to mid-bit
                    if (r_rx_baud == c_BAUD_HALF) begin
                        r_rx_baud  <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_rx_baud == c_BAUD_LAST) begin
                        r_rx_baud  <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_bit   <= 3'd0;
                            r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_rx_baud == c_BAUD_LAST) begin
                        r_rx_baud  <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= ST_IDLE;
                        if (r_rx_s2) begin
                            // A read finishing on this edge consumed the old byte,
                            // so it does not count as an overrun.
                            r_rbr        <= r_rx_shift;
                            r_data_ready <= 1'b1;
                            r_overrun    <= ~w_rd_edge & (r_overrun | r_data_ready);
                        end
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    assign data_o       = r_rbr;
    assign data_oe_o    = r_data_oe;
    assign data_ready_o = r_data_ready;
    assign tbre_o       = r_tbre;
    assign tsre_o       = r_tsre;
    assign overrun_o    = r_overrun;
    assign txd_o        = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_responder
// Description : Directed self-checking bench for uart_bus_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_responder;

    localparam int c_CPB = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wrn_i = 1'b1;
    logic       rdn_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       data_oe_o, data_ready_o, tbre_o, tsre_o, overrun_o, txd_o;
    logic       rxd_i;
    logic       rx_drv = 1'b1;
    logic       lb_en = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    assign rxd_i = lb_en ? txd_o : rx_drv;

    always #5 CLK = ~CLK;

    uart_bus_responder #(.CLKS_PER_BIT(c_CPB)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wrn_i        (wrn_i),
        .rdn_i        (rdn_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .data_oe_o    (data_oe_o),
        .data_ready_o (data_ready_o),
        .tbre_o       (tbre_o),
        .tsre_o       (tsre_o),
        .overrun_o    (overrun_o),
        .txd_o        (txd_o),
        .rxd_i        (rxd_i)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic write_byte(input logic [7:0] b);
        @(negedge CLK);
        data_i = b;
        wrn_i  = 1'b0;
        @(negedge CLK);
        wrn_i  = 1'b1;
    endtask

    task automatic wait_tx_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (txd_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (data_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            rx_drv = frame[k];
            repeat (c_CPB - 1) @(negedge CLK);
        end
        @(negedge CLK);
        rx_drv = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    task automatic pulse_read();
        @(negedge CLK);
        rdn_i = 1'b0;
        @(negedge CLK);
        rdn_i = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run++; if (txd_o !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got %b want 1", txd_o); end
        tests_run++; if (tbre_o !== 1'b1) begin tests_failed++; $display("FAIL reset_tbre got %b want 1", tbre_o); end
        tests_run++; if (tsre_o !== 1'b1) begin tests_failed++; $display("FAIL reset_tsre got %b want 1", tsre_o); end
        tests_run++; if (data_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", data_ready_o); end
        tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun_o); end
        tests_run++; if (data_oe_o !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got %b want 0", data_oe_o); end
        tests_run++; if (data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", data_o); end
    endtask

    task automatic test_reset_mid_tx();
        bit ok;
        write_byte(8'hA5);
        wait_tx_start(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rst_mid_start txd never fell"); end
        // centre of data bit 3 (frame index 4); 0xA5 bit3 = 0
        repeat (8 + 16 * 4) @(negedge CLK);
        tests_run++; if (txd_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_bit3 got %b want 0", txd_o); end
        RST = 1'b1;
        @(negedge CLK);
        tests_run++; if (txd_o !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_txd got %b want 1", txd_o); end
        tests_run++; if (tbre_o !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_tbre got %b want 1", tbre_o); end
        tests_run++; if (tsre_o !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_tsre got %b want 1", tsre_o); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_single_tx();
        logic [9:0] exp_frame;
        bit ok;
        int tsre_at;
        exp_frame = {1'b1, 8'h3C, 1'b0};
        tsre_at = -1;
        write_byte(8'h3C);
        wait_tx_start(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL tx1_start txd never fell"); end
        tests_run++; if (tbre_o !== 1'b1 || tsre_o !== 1'b0) begin tests_failed++; $display("FAIL tx1_flags tbre=%b tsre=%b want 1/0", tbre_o, tsre_o); end
        for (int cnt = 1; cnt <= 400; cnt++) begin
            @(negedge CLK);
            if (cnt >= 8 && ((cnt - 8) % 16) == 0 && ((cnt - 8) / 16) < 10) begin
                tests_run++;
                if (txd_o !== exp_frame[(cnt - 8) / 16]) begin
                    tests_failed++;
                    $display("FAIL tx1_bit%0d got %b want %b", (cnt - 8) / 16, txd_o, exp_frame[(cnt - 8) / 16]);
                end
            end
            if (tsre_o === 1'b1) begin
                tsre_at = cnt;
                break;
            end
        end
        tests_run++; if (tsre_at != 160) begin tests_failed++; $display("FAIL tx1_tsre_time got %0d want 160", tsre_at); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_frames;
        bit ok;
        int tsre_at;
        exp_frames = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
        tsre_at = -1;
        write_byte(8'h55);
        wait_tx_start(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_start txd never fell"); end
        tests_run++; if (tbre_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_tbre got %b want 1", tbre_o); end
        for (int cnt = 1; cnt <= 600; cnt++) begin
            @(negedge CLK);
            if (cnt == 2) begin data_i = 8'hAA; wrn_i = 1'b0; end
            if (cnt == 3) wrn_i = 1'b1;
            if (cnt >= 8 && ((cnt - 8) % 16) == 0 && ((cnt - 8) / 16) < 20) begin
                tests_run++;
                if (txd_o !== exp_frames[(cnt - 8) / 16]) begin
                    tests_failed++;
                    $display("FAIL b2b_bit%0d got %b want %b", (cnt - 8) / 16, txd_o, exp_frames[(cnt - 8) / 16]);
                end
            end
            if (tsre_o === 1'b1) begin
                tsre_at = cnt;
                break;
            end
        end
        tests_run++; if (tsre_at != 320) begin tests_failed++; $display("FAIL b2b_tsre_time got %0d want 320", tsre_at); end
    endtask

    task automatic test_rx_read();
        bit ok;
        send_serial(8'h81, 1'b1);
        wait_ready(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rx_ready got %b want 1", data_ready_o); end
        tests_run++; if (data_oe_o !== 1'b0) begin tests_failed++; $display("FAIL rx_oe_idle got %b want 0", data_oe_o); end
        @(negedge CLK);
        rdn_i = 1'b0;
        @(negedge CLK);
        tests_run++; if (data_oe_o !== 1'b1) begin tests_failed++; $display("FAIL rx_oe got %b want 1", data_oe_o); end
        tests_run++; if (data_o !== 8'h81) begin tests_failed++; $display("FAIL rx_data got %h want 81", data_o); end
        tests_run++; if (data_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_during_read got %b want 1", data_ready_o); end
        rdn_i = 1'b1;
        repeat (3) @(negedge CLK);
        tests_run++; if (data_ready_o !== 1'b0) begin tests_failed++; $display("FAIL rx_ready_clear got %b want 0", data_ready_o); end
        tests_run++; if (data_oe_o !== 1'b0) begin tests_failed++; $display("FAIL rx_oe_release got %b want 0", data_oe_o); end
    endtask

    task automatic test_overrun_framing();
        send_serial(8'h11, 1'b1);
        tests_run++; if (data_o !== 8'h11 || overrun_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_first data=%h ovr=%b want 11/0", data_o, overrun_o); end
        send_serial(8'h22, 1'b1);
        tests_run++; if (data_o !== 8'h22) begin tests_failed++; $display("FAIL ovr_data got %h want 22", data_o); end
        tests_run++; if (overrun_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b want 1", overrun_o); end
        send_serial(8'h5A, 1'b0);
        tests_run++; if (data_o !== 8'h22) begin tests_failed++; $display("FAIL frm_data got %h want 22", data_o); end
        tests_run++; if (overrun_o !== 1'b1 || data_ready_o !== 1'b1) begin tests_failed++; $display("FAIL frm_flags ovr=%b rdy=%b want 1/1", overrun_o, data_ready_o); end
        pulse_read();
        tests_run++; if (overrun_o !== 1'b0 || data_ready_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear ovr=%b rdy=%b want 0/0", overrun_o, data_ready_o); end
    endtask

    task automatic test_loopback();
        bit ok;
        lb_en = 1'b1;
        repeat (4) @(negedge CLK);
        for (int b = 0; b < 256; b++) begin
            write_byte(8'(b));
            wait_ready(ok);
            tests_run++;
            if (!ok || data_o !== 8'(b) || overrun_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL loopback_%02h got %h ready=%b ovr=%b want %02h/1/0", b[7:0], data_o, ok, overrun_o, b[7:0]);
            end
            pulse_read();
        end
        lb_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_tx();
        test_single_tx();
        repeat (5) @(negedge CLK);
        test_back_to_back();
        repeat (5) @(negedge CLK);
        test_rx_read();
        test_overrun_framing();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
